// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: the producer write port and the transmitter launch port
// of uart_tx_fifo, bundled together.
//   wr_valid/wr_data/wr_ready : producer -> FIFO valid/ready write port
//   tx_start/tx_data/tx_busy  : FIFO -> uart_top transmitter launch port
// The slave modport is the FIFO. The master modport is its environment: the
// producer drives the write side, and the transmitter drives tx_busy.
interface uart_tx_fifo_if #(
   parameter int PAYLOAD_BITS = 8
);
   logic                    wr_valid;
   logic [PAYLOAD_BITS-1:0] wr_data;
   logic                    wr_ready;
   logic                    tx_start;
   logic [PAYLOAD_BITS-1:0] tx_data;
   logic                    tx_busy;

   modport master (
      output wr_valid, wr_data, tx_busy,
      input  wr_ready, tx_start, tx_data
   );

   modport slave (
      input  wr_valid, wr_data, tx_busy,
      output wr_ready, tx_start, tx_data
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: DEPTH-entry byte buffer sitting in front of the uart_top
// transmitter. Words are queued through a valid/ready port and launched one
// at a time with a single-cycle tx_start pulse. Each launch must be
// acknowledged by tx_busy rising within BUSY_TIMEOUT cycles.
// Ports:
//   clk, rst   clock; synchronous active-high reset
//   flush      clears the queue; a frame already in flight is not aborted
//   bus        write port and transmitter port (slave modport)
//   level      occupancy 0..DEPTH; empty/full are derived from it
//   start_err  sticky flag: a launch was never acknowledged by tx_busy
module uart_tx_fifo #(
   parameter int PAYLOAD_BITS = 8,
   parameter int DEPTH        = 16,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   uart_tx_fifo_if.slave          bus,
   output logic [$clog2(DEPTH):0] level,
   output logic                   empty,
   output logic                   full,
   output logic                   start_err
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

   state_t                  state, state_nxt;
   logic [PAYLOAD_BITS-1:0] mem [DEPTH];
   logic [AW-1:0]           wr_ptr, rd_ptr;
   logic [TW-1:0]           tmr;
   logic                    wr_en, pop, timeout;

   assign empty        = (level == '0);
   assign full         = (level == LW'(DEPTH));
   assign bus.wr_ready = ~full & ~rst & ~flush;
   assign wr_en        = bus.wr_valid & bus.wr_ready;

   // ---------------- FIFO storage and pointers ----------------
   // The pointers wrap on their own because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= bus.wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: ;
         endcase
      end
   end

   // ---------------- launch sequencer ----------------
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (pop) state_nxt = WAIT_BUSY;
         WAIT_BUSY: if (bus.tx_busy) state_nxt = WAIT_DONE;
                    else if (timeout) state_nxt = IDLE;
         WAIT_DONE: if (!bus.tx_busy) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // A pop only happens in IDLE with the link idle. This also covers the
   // case where reset left a frame running: IDLE waits for tx_busy to drop.
   always_comb begin
      pop     = 1'b0;
      timeout = 1'b0;
      case (state)
         IDLE:      pop     = ~empty & ~bus.tx_busy & ~flush;
         WAIT_BUSY: timeout = ~bus.tx_busy & (tmr == TW'(BUSY_TIMEOUT - 1));
         default:   ;
      endcase
   end

   // tmr counts completed cycles in WAIT_BUSY with tx_busy still low. The
   // timeout fires on the edge that ends the BUSY_TIMEOUT-th such cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.tx_start <= 1'b0;
         bus.tx_data  <= '0;
         start_err    <= 1'b0;
         tmr          <= '0;
      end else begin
         bus.tx_start <= pop;
         if (pop)     bus.tx_data <= mem[rd_ptr];
         if (timeout) start_err   <= 1'b1;
         if (state == WAIT_BUSY && !bus.tx_busy) tmr <= tmr + TW'(1);
         else                                    tmr <= '0;
      end
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo.
// The bench contains three parts:
//   - A transmitter model. On a tx_start pulse it stays busy for a frame
//     length. It can also be forced to hold tx_busy stuck high or stuck low.
//   - A queue-based scoreboard that checks occupancy, flags, wr_ready,
//     launch order and tx_data on every cycle.
//   - A table of fill vectors plus directed sequences for the multi-cycle
//     corner cases, followed by a randomized phase.
module tb_uart_tx_fifo;
   localparam int PB = 8;
   localparam int D  = 16;
   localparam int TO = 4;
   localparam int LW = $clog2(D) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic [LW-1:0] level;
   logic          empty, full, start_err;

   uart_tx_fifo_if #(.PAYLOAD_BITS(PB)) bus ();

   uart_tx_fifo #(.PAYLOAD_BITS(PB), .DEPTH(D), .BUSY_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .flush(flush), .bus(bus),
      .level(level), .empty(empty), .full(full), .start_err(start_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- transmitter model ----------------
   // mode 0 = normal frames, 1 = tx_busy stuck high, 2 = tx_busy stuck low
   int          mode = 0;
   int          cnt = 0;
   int          frame_len = 3;
   bit          rand_len = 1'b0;
   logic [7:0]  launched [$];

   // ---------------- scoreboard ----------------
   logic [7:0]  mq [$];
   logic [7:0]  last_tx = 8'h00;
   logic        acc_s = 1'b0, rst_s = 1'b1, flush_s = 1'b0, busy_s = 1'b0;
   logic [7:0]  data_s = 8'h00;
   logic        prev_start = 1'b0;

   // Capture the values the DUT sees at the active edge.
   always @(posedge clk) begin
      acc_s   = bus.wr_valid & bus.wr_ready;
      data_s  = bus.wr_data;
      rst_s   = rst;
      flush_s = flush;
      busy_s  = bus.tx_busy;
   end

   always @(negedge clk) begin
      if (rst_s) begin
         mq.delete();
         last_tx = 8'h00;
         chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
         chk("rst_start_err", 32'(start_err), 32'd0);
      end else if (flush_s) begin
         mq.delete();
      end else begin
         if (bus.tx_start) begin
            chk("launch_nonempty", 32'(mq.size() != 0), 32'd1);
            chk("launch_link_idle", 32'(busy_s), 32'd0);
            chk("single_cycle_start", 32'(prev_start), 32'd0);
            if (mq.size() != 0) begin
               chk("launch_order", 32'(bus.tx_data), 32'(mq[0]));
               last_tx = mq.pop_front();
            end
         end
         if (acc_s) mq.push_back(data_s);
      end
      chk("level", 32'(level), 32'(mq.size()));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("full", 32'(full), 32'(mq.size() == D));
      chk("wr_ready", 32'(bus.wr_ready), 32'((mq.size() < D) && !rst && !flush));
      chk("tx_data_hold", 32'(bus.tx_data), 32'(last_tx));
      prev_start = bus.tx_start;

      case (mode)
         1: begin cnt = 0; bus.tx_busy = 1'b1; end
         2: begin cnt = 0; bus.tx_busy = 1'b0; end
         default: begin
            if (cnt > 0) cnt--;
            if (bus.tx_start) cnt = rand_len ? int'($urandom_range(1, 6)) : frame_len;
            bus.tx_busy = (cnt > 0);
         end
      endcase
      if (bus.tx_start) launched.push_back(bus.tx_data);
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not end, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic wr(input logic [7:0] d);
      bus.wr_valid = 1'b1;
      bus.wr_data  = d;
      tick();
      bus.wr_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (!(empty && !bus.tx_busy && !bus.tx_start) && n < 2000) begin
         tick();
         n++;
      end
      chk({name, "_drain_in_time"}, 32'(n < 2000), 32'd1);
      idle(2);
   endtask

   task automatic chk_launched(input string name, input logic [7:0] exp [$]);
      chk({name, "_count"}, 32'(launched.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < launched.size(); i++)
         chk({name, "_word"}, 32'(launched[i]), 32'(exp[i]));
   endtask

   typedef struct {
      logic       wv;
      logic [7:0] d;
      int         lvl;
      logic       f;
      logic       e;
      logic       rdy;
   } vec_t;

   vec_t       vt [18];
   logic [7:0] exp_q [$];

   initial begin
      // Fill vectors, applied with tx_busy stuck high so nothing drains.
      // Each row gives the inputs, then the state expected after the edge
      // (inputs still applied).
      for (int i = 0; i < 16; i++)
         vt[i] = '{1'b1, 8'(i), i + 1, (i == 15), 1'b0, (i != 15)};
      vt[16] = '{1'b1, 8'hFF, 16, 1'b1, 1'b0, 1'b0};   // write while full: dropped
      vt[17] = '{1'b0, 8'h00, 16, 1'b1, 1'b0, 1'b0};

      bus.wr_valid = 1'b0;
      bus.wr_data  = 8'h00;

      // ---- reset state ----
      idle(3);
      chk("reset_wr_ready", 32'(bus.wr_ready), 32'd0);
      chk("reset_level", 32'(level), 32'd0);
      chk("reset_empty", 32'(empty), 32'd1);
      chk("reset_full", 32'(full), 32'd0);
      chk("reset_tx_start", 32'(bus.tx_start), 32'd0);
      chk("reset_tx_data", 32'(bus.tx_data), 32'd0);
      chk("reset_start_err", 32'(start_err), 32'd0);
      rst = 1'b0;
      tick();

      // ---- single word: latency and one pulse ----
      launched.delete();
      wr(8'hA5);
      chk("t1_level_after_write", 32'(level), 32'd1);
      chk("t1_no_start_yet", 32'(bus.tx_start), 32'd0);
      tick();
      chk("t1_start", 32'(bus.tx_start), 32'd1);
      chk("t1_data", 32'(bus.tx_data), 32'hA5);
      chk("t1_level_after_pop", 32'(level), 32'd0);
      tick();
      chk("t1_start_one_cycle", 32'(bus.tx_start), 32'd0);
      drain("t1");
      exp_q = '{8'hA5};
      chk_launched("t1_launched", exp_q);

      // ---- fill to full from the vector table, then release ----
      mode = 1;
      tick();
      launched.delete();
      for (int i = 0; i < 18; i++) begin
         bus.wr_valid = vt[i].wv;
         bus.wr_data  = vt[i].d;
         tick();
         chk("vec_level", 32'(level), 32'(vt[i].lvl));
         chk("vec_full", 32'(full), 32'(vt[i].f));
         chk("vec_empty", 32'(empty), 32'(vt[i].e));
         chk("vec_wr_ready", 32'(bus.wr_ready), 32'(vt[i].rdy));
      end
      bus.wr_valid = 1'b0;
      mode = 0;
      drain("t2");
      exp_q.delete();
      for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
      chk_launched("t2_launched", exp_q);

      // ---- simultaneous write and pop at level 8 ----
      mode = 1;
      tick();
      launched.delete();
      exp_q.delete();
      for (int i = 0; i < 8; i++) begin
         wr(8'h80 + 8'(i));
         exp_q.push_back(8'h80 + 8'(i));
      end
      chk("t3_level8", 32'(level), 32'd8);
      mode = 0;
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'h88;
      tick();
      bus.wr_valid = 1'b0;
      exp_q.push_back(8'h88);
      chk("t3_same_cycle_start", 32'(bus.tx_start), 32'd1);
      chk("t3_same_cycle_level", 32'(level), 32'd8);
      drain("t3");
      chk_launched("t3_launched", exp_q);

      // ---- 40 words through a throttled consumer (pointer wrap) ----
      rand_len = 1'b1;
      launched.delete();
      exp_q.delete();
      for (int i = 0; i < 40; i++) begin
         logic [7:0] d;
         int n;
         d = 8'($urandom);
         n = 0;
         while (!bus.wr_ready && n < 200) begin tick(); n++; end
         chk("t3w_ready_in_time", 32'(n < 200), 32'd1);
         wr(d);
         exp_q.push_back(d);
         idle(int'($urandom_range(0, 2)));
      end
      drain("t3w");
      chk_launched("t3w_launched", exp_q);
      rand_len = 1'b0;

      // ---- flush during a frame ----
      frame_len = 12;
      launched.delete();
      bus.wr_valid = 1'b1;
      bus.wr_data = 8'h11; tick();
      bus.wr_data = 8'h22; tick();
      bus.wr_data = 8'h33; tick();
      bus.wr_valid = 1'b0;
      chk("t4_level_before_flush", 32'(level), 32'd2);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t4_level_after_flush", 32'(level), 32'd0);
      chk("t4_empty_after_flush", 32'(empty), 32'd1);
      drain("t4");
      exp_q = '{8'h11};
      chk_launched("t4_launched", exp_q);

      // ---- stalled transmitter: start_err after the timeout ----
      mode = 2;
      tick();
      launched.delete();
      bus.wr_valid = 1'b1;
      bus.wr_data = 8'h55; tick();
      bus.wr_data = 8'h66; tick();
      bus.wr_valid = 1'b0;
      chk("t5_start", 32'(bus.tx_start), 32'd1);
      chk("t5_data", 32'(bus.tx_data), 32'h55);
      for (int k = 1; k <= TO; k++) begin
         tick();
         chk("t5_start_err", 32'(start_err), 32'(k == TO));
      end
      mode = 0;
      tick();
      chk("t5_next_start", 32'(bus.tx_start), 32'd1);
      chk("t5_next_data", 32'(bus.tx_data), 32'h66);
      drain("t5");
      exp_q = '{8'h55, 8'h66};
      chk_launched("t5_launched", exp_q);
      chk("t5_err_sticky", 32'(start_err), 32'd1);

      // ---- reset mid-frame with three words queued ----
      launched.delete();
      bus.wr_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.wr_data = 8'hA1 + 8'(i);
         tick();
      end
      bus.wr_valid = 1'b0;
      chk("t6_level_queued", 32'(level), 32'd3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_level", 32'(level), 32'd0);
      chk("t6_start_err", 32'(start_err), 32'd0);
      chk("t6_tx_start", 32'(bus.tx_start), 32'd0);
      chk("t6_busy_still_high", 32'(bus.tx_busy), 32'd1);
      begin
         int n = 0;
         while (bus.tx_busy && n < 100) begin tick(); n++; end
         chk("t6_busy_falls", 32'(n < 100), 32'd1);
      end
      idle(5);
      exp_q = '{8'hA1};
      chk_launched("t6_no_new_launch", exp_q);
      wr(8'h99);
      tick();
      chk("t6_new_start", 32'(bus.tx_start), 32'd1);
      chk("t6_new_data", 32'(bus.tx_data), 32'h99);
      drain("t6");

      // ---- randomized traffic; the scoreboard checks every cycle ----
      rand_len = 1'b1;
      for (int c = 0; c < 1500; c++) begin
         bus.wr_valid = ($urandom_range(0, 99) < 60);
         bus.wr_data  = 8'($urandom);
         flush        = ($urandom_range(0, 99) < 2);
         rst          = ($urandom_range(0, 199) < 1);
         tick();
      end
      bus.wr_valid = 1'b0;
      flush = 1'b0;
      rst = 1'b0;
      drain("rand");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
